// File: rtl/haar_stage_streamer_if.sv
// Memory read port and output word stream of the Haar cascade stage streamer.
// The streamer connects through the master modport; the memory and consumer side use the slave modport.
interface haar_stage_streamer_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 12
);
    logic                  o_mem_rd;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic [DATA_WIDTH-1:0] i_mem_data;
    logic                  o_valid;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] o_data;
    logic [11:0]           o_index_classifier;
    logic [4:0]            o_index_param;
    logic                  o_is_threshold;
    logic                  o_end_classifier;
    logic                  o_end_stage;

    modport master (
        output o_mem_rd, o_mem_addr,
        input  i_mem_data,
        output o_valid,
        input  i_ready,
        output o_data, o_index_classifier, o_index_param,
        output o_is_threshold, o_end_classifier, o_end_stage
    );

    modport slave (
        input  o_mem_rd, o_mem_addr,
        output i_mem_data,
        input  o_valid,
        output i_ready,
        input  o_data, o_index_classifier, o_index_param,
        input  o_is_threshold, o_end_classifier, o_end_stage
    );
endinterface

// File: rtl/haar_stage_streamer.sv
// Reads one cascade stage's header, then streams its classifier and threshold words
// through a 2-entry output FIFO with at most two words buffered or in flight.
//
//   state      | meaning
//   IDLE       | waiting for i_start
//   HDR_BASE   | read stage base address (2s)
//   HDR_CNT    | latch base, read classifier count (2s+1)
//   CNT_WAIT   | latch N; reject N == 0
//   STREAM     | issue reads base+0 .. base+W-1
//   DRAIN      | all reads issued, wait for the last word to be taken
module haar_stage_streamer #(
    parameter int ADDR_WIDTH               = 12,
    parameter int DATA_WIDTH               = 12,
    parameter int NUM_STAGES               = 25,
    parameter int NUM_PARAM_PER_CLASSIFIER = 18,
    parameter int NUM_STAGE_THRESHOLD      = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         i_start,
    input  logic [4:0]                   i_stage,
    input  logic                         i_abort,
    haar_stage_streamer_if.master        bus,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_err
);
    typedef enum logic [2:0] {
        S_IDLE, S_HDR_BASE, S_HDR_CNT, S_CNT_WAIT, S_STREAM, S_DRAIN
    } state_t;

    typedef struct packed {
        logic [11:0] cls;
        logic [4:0]  prm;
        logic        thr;
        logic        endc;
        logic        ends;
    } meta_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        meta_t                 meta;
    } word_t;

    state_t                r_state, w_next;
    logic [4:0]            r_stage;
    logic [ADDR_WIDTH-1:0] r_base, r_addr;
    logic [11:0]           r_n, w_n;
    logic [31:0]           r_remain;
    logic [11:0]           r_iss_cls;
    logic [4:0]            r_iss_prm;
    logic                  r_iss_thr;
    logic                  r_inf;
    meta_t                 r_inf_meta, w_iss_meta;
    word_t                 r_fifo [2];
    logic                  r_wp, r_rp;
    logic [1:0]            r_occ;
    logic                  r_done, r_rst_q;
    word_t                 w_head;
    logic                  w_quiet, w_pop, w_push, w_issue, w_rd_hdr, w_stage_ok, w_n_zero;
    logic [2:0]            w_level;

    assign w_n        = 12'(bus.i_mem_data);
    assign w_n_zero   = (bus.i_mem_data == '0);
    assign w_stage_ok = (32'(i_stage) < NUM_STAGES);
    assign w_head     = r_fifo[r_rp];
    assign w_quiet    = reset | r_rst_q;
    // Abort wins over a same-cycle handshake, so the word is not consumed.
    assign w_pop      = (r_occ != 2'd0) && bus.i_ready && !i_abort;
    assign w_push     = r_inf && !i_abort;
    assign w_level    = {1'b0, r_occ} + {2'b0, r_inf} - {2'b0, w_pop};
    assign w_issue    = (r_state == S_STREAM) && (r_remain != 32'd0) && (w_level < 3'd2)
                        && !i_abort && !reset;
    assign w_rd_hdr   = ((r_state == S_HDR_BASE) || (r_state == S_HDR_CNT)) && !i_abort;

    assign w_iss_meta.cls  = r_iss_cls;
    assign w_iss_meta.prm  = r_iss_prm;
    assign w_iss_meta.thr  = r_iss_thr;
    assign w_iss_meta.endc = !r_iss_thr && (r_iss_prm == 5'(NUM_PARAM_PER_CLASSIFIER - 1));
    assign w_iss_meta.ends = (r_remain == 32'd1);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:     if (i_start && !r_done && !r_rst_q && w_stage_ok) w_next = S_HDR_BASE;
            S_HDR_BASE: w_next = S_HDR_CNT;
            S_HDR_CNT:  w_next = S_CNT_WAIT;
            S_CNT_WAIT: w_next = w_n_zero ? S_IDLE : S_STREAM;
            S_STREAM:   if (w_issue && (r_remain == 32'd1)) w_next = S_DRAIN;
            S_DRAIN:    if (w_pop && w_head.meta.ends) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
        if (i_abort && (r_state != S_IDLE)) w_next = S_IDLE;
    end

    always_comb begin
        bus.o_mem_rd           = 1'b0;
        bus.o_mem_addr         = '0;
        bus.o_valid            = 1'b0;
        bus.o_data             = '0;
        bus.o_index_classifier = '0;
        bus.o_index_param      = '0;
        bus.o_is_threshold     = 1'b0;
        bus.o_end_classifier   = 1'b0;
        bus.o_end_stage        = 1'b0;
        o_busy                 = 1'b0;
        o_done                 = 1'b0;
        o_err                  = 1'b0;
        if (!w_quiet) begin
            bus.o_mem_rd = w_rd_hdr || w_issue;
            if (w_rd_hdr)     bus.o_mem_addr = ADDR_WIDTH'({r_stage, r_state == S_HDR_CNT});
            else if (w_issue) bus.o_mem_addr = r_addr;
            if (r_occ != 2'd0) begin
                bus.o_valid            = 1'b1;
                bus.o_data             = w_head.data;
                bus.o_index_classifier = w_head.meta.cls;
                bus.o_index_param      = w_head.meta.prm;
                bus.o_is_threshold     = w_head.meta.thr;
                bus.o_end_classifier   = w_head.meta.endc;
                bus.o_end_stage        = w_head.meta.ends;
            end
            o_busy = (r_state != S_IDLE);
            o_done = r_done;
            o_err  = ((r_state == S_IDLE) && i_start && !r_done && !w_stage_ok)
                     || ((r_state == S_CNT_WAIT) && w_n_zero && !i_abort);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stage    <= '0;
            r_base     <= '0;
            r_addr     <= '0;
            r_n        <= '0;
            r_remain   <= '0;
            r_iss_cls  <= '0;
            r_iss_prm  <= '0;
            r_iss_thr  <= 1'b0;
            r_inf      <= 1'b0;
            r_inf_meta <= '0;
            r_wp       <= 1'b0;
            r_rp       <= 1'b0;
            r_occ      <= '0;
            r_done     <= 1'b0;
            r_rst_q    <= 1'b1;
        end else begin
            r_rst_q <= 1'b0;
            r_done  <= (r_state == S_DRAIN) && w_pop && w_head.meta.ends;
            if ((r_state == S_IDLE) && (w_next == S_HDR_BASE)) r_stage <= i_stage;
            if (r_state == S_HDR_CNT) r_base <= ADDR_WIDTH'(bus.i_mem_data);
            if (r_state == S_CNT_WAIT) begin
                r_n       <= w_n;
                r_remain  <= 32'(w_n) * NUM_PARAM_PER_CLASSIFIER + NUM_STAGE_THRESHOLD;
                r_addr    <= r_base;
                r_iss_cls <= '0;
                r_iss_prm <= '0;
                r_iss_thr <= 1'b0;
            end
            if (w_issue) begin
                r_addr   <= r_addr + 1'b1;
                r_remain <= r_remain - 32'd1;
                // After the last classifier word the class index lands on N for the thresholds.
                if (!r_iss_thr && (r_iss_prm == 5'(NUM_PARAM_PER_CLASSIFIER - 1))) begin
                    r_iss_prm <= '0;
                    r_iss_cls <= r_iss_cls + 12'd1;
                    if (r_iss_cls == r_n - 12'd1) r_iss_thr <= 1'b1;
                end else begin
                    r_iss_prm <= r_iss_prm + 5'd1;
                end
                r_inf_meta <= w_iss_meta;
            end
            r_inf <= w_issue;
            if (i_abort) begin
                r_occ <= '0;
                r_wp  <= 1'b0;
                r_rp  <= 1'b0;
            end else begin
                if (w_push) r_wp <= ~r_wp;
                if (w_pop)  r_rp <= ~r_rp;
                r_occ <= r_occ + {1'b0, w_push} - {1'b0, w_pop};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !reset) r_fifo[r_wp] <= '{data: bus.i_mem_data, meta: r_inf_meta};
    end
endmodule

// File: tb/tb_haar_stage_streamer.sv
// Self-checking bench for haar_stage_streamer: memory model, expected-word scoreboard
// and a monitor that checks every read address, handshake and stall.
module tb_haar_stage_streamer;
    localparam int AW = 12;
    localparam int DW = 12;
    localparam int NP = 18;
    localparam int NT = 3;

    typedef struct packed {
        logic [11:0] data;
        logic [11:0] cls;
        logic [4:0]  prm;
        logic        thr;
        logic        endc;
        logic        ends;
    } exp_t;

    typedef struct packed {
        logic [11:0] addr;
        logic        hdr;
    } rd_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_start = 1'b0;
    logic       i_abort = 1'b0;
    logic [4:0] i_stage = '0;
    logic       o_busy, o_done, o_err;
    logic [11:0] mem [0:4095];
    logic [11:0] mem_q = '0;

    int errors = 0;
    int checks = 0;
    int cyc_cnt = 0;
    int out_cnt = 0;
    int words_seen = 0;
    int endc_seen = 0;
    int ends_cyc = -1;
    bit   prev_stall = 1'b0;
    exp_t prev_obs;
    exp_t exp_q [$];
    rd_t  addr_q [$];

    haar_stage_streamer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    haar_stage_streamer #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_STAGES(25),
        .NUM_PARAM_PER_CLASSIFIER(NP), .NUM_STAGE_THRESHOLD(NT)
    ) dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_stage(i_stage), .i_abort(i_abort),
        .bus(bus), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt++;
    always @(posedge clk) if (bus.o_mem_rd) mem_q <= mem[bus.o_mem_addr];
    assign bus.i_mem_data = mem_q;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        exp_t obs;
        exp_t e;
        rd_t  r;
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            obs = {bus.o_data, bus.o_index_classifier, bus.o_index_param,
                   bus.o_is_threshold, bus.o_end_classifier, bus.o_end_stage};
            if (prev_stall) begin
                checks++;
                if (bus.o_valid !== 1'b1 || obs !== prev_obs) begin
                    errors++;
                    $display("FAIL hold_under_stall: valid=%b word=%h, required valid=1 word=%h",
                             bus.o_valid, obs, prev_obs);
                end
            end
            if (bus.o_valid && bus.i_ready && !i_abort) begin
                out_cnt--;
                words_seen++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL word_unexpected: got %h, required no word", obs);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        errors++;
                        $display("FAIL word_%0d: got %h, required %h", words_seen - 1, obs, e);
                    end
                end
                if (bus.o_end_classifier) endc_seen++;
                if (bus.o_end_stage) ends_cyc = cyc_cnt;
            end
            if (bus.o_mem_rd) begin
                checks++;
                if (addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL read_unexpected: addr=%h, required no read", bus.o_mem_addr);
                end else begin
                    r = addr_q.pop_front();
                    if (bus.o_mem_addr !== r.addr) begin
                        errors++;
                        $display("FAIL read_addr: got %h, required %h", bus.o_mem_addr, r.addr);
                    end
                    if (!r.hdr) out_cnt++;
                end
                checks++;
                if (out_cnt > 2) begin
                    errors++;
                    $display("FAIL outstanding: got %0d, required <= 2", out_cnt);
                end
            end
            prev_stall = bus.o_valid && !bus.i_ready && !i_abort;
            prev_obs   = obs;
        end
    end

    task automatic push_stage(input int s);
        int base, n, w, a;
        exp_t e;
        rd_t  r;
        base = int'(mem[2*s]);
        n    = int'(mem[2*s+1]);
        r.hdr = 1'b1;
        r.addr = 12'(2*s);     addr_q.push_back(r);
        r.addr = 12'(2*s + 1); addr_q.push_back(r);
        if (n != 0) begin
            w = n*NP + NT;
            for (int k = 0; k < w; k++) begin
                a = (base + k) % 4096;
                r.addr = 12'(a);
                r.hdr  = 1'b0;
                addr_q.push_back(r);
                e.data = mem[a];
                if (k < n*NP) begin
                    e.cls = 12'(k / NP); e.prm = 5'(k % NP); e.thr = 1'b0;
                    e.endc = (k % NP == NP - 1); e.ends = 1'b0;
                end else begin
                    e.cls = 12'(n); e.prm = 5'(k - n*NP); e.thr = 1'b1;
                    e.endc = 1'b0; e.ends = (k == w - 1);
                end
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic clear_track();
        exp_q.delete();
        addr_q.delete();
        out_cnt = 0;
        words_seen = 0;
        endc_seen = 0;
        ends_cyc = -1;
    endtask

    // Leaves the caller at cycle 1 (just after the edge that samples i_start).
    task automatic start_stage(input int s);
        @(posedge clk); #1;
        i_stage = 5'(s);
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit seen);
        seen = 1'b0;
        for (int c = 0; c < limit; c++) begin
            @(negedge clk);
            if (o_done) begin seen = 1'b1; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        logic [63:0] outs;
        reset = 1'b1; i_start = 1'b1; i_abort = 1'b1; i_stage = 5'd25; bus.i_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            outs = 64'({bus.o_valid, bus.o_mem_rd, bus.o_mem_addr, bus.o_data, bus.o_index_classifier,
                        bus.o_index_param, bus.o_is_threshold, bus.o_end_classifier, bus.o_end_stage,
                        o_busy, o_done, o_err});
            checks++;
            if (outs !== 64'd0) begin
                errors++;
                $display("FAIL reset_outputs_%0d: got %h, required 0", c, outs);
            end
        end
        @(posedge clk); #1;
        reset = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_stage = '0;
        @(negedge clk);
        outs = 64'({bus.o_valid, bus.o_mem_rd, bus.o_mem_addr, bus.o_data, o_busy, o_done, o_err});
        checks++;
        if (outs !== 64'd0) begin
            errors++;
            $display("FAIL reset_after_outputs: got %h, required 0", outs);
        end
    endtask

    task automatic test_basic();
        int first, first_cyc, done_cyc;
        bit found;
        clear_track();
        push_stage(0);
        bus.i_ready = 1'b1;
        start_stage(0);
        first = 0; first_cyc = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.o_valid) begin first = c; first_cyc = cyc_cnt; break; end
            @(posedge clk); #1;
        end
        checks++;
        if (first != 6) begin
            errors++;
            $display("FAIL first_valid_cycle: got %0d, required 6", first);
        end
        @(posedge clk); #1;
        i_stage = 5'd1; i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.o_valid && bus.o_end_stage) begin found = 1'b1; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        i_stage = 5'd1; i_start = 1'b1;
        @(negedge clk);
        done_cyc = cyc_cnt;
        checks++;
        if (!found || o_done !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: found=%b done=%b busy=%b, required 1 1 0", found, o_done, o_busy);
        end
        @(posedge clk); #1;
        i_start = 1'b0;
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            errors++;
            $display("FAIL start_on_done_ignored: busy=%b done=%b, required 0 0", o_busy, o_done);
        end
        checks++;
        if (done_cyc != ends_cyc + 1) begin
            errors++;
            $display("FAIL done_latency: got %0d, required %0d", done_cyc, ends_cyc + 1);
        end
        checks++;
        if (ends_cyc - first_cyc != 38) begin
            errors++;
            $display("FAIL throughput: got %0d cycles, required 38", ends_cyc - first_cyc);
        end
        checks++;
        if (words_seen != 39 || endc_seen != 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL basic_count: words=%0d endc=%0d left=%0d, required 39 2 0",
                     words_seen, endc_seen, exp_q.size());
        end
    endtask

    task automatic test_backpressure();
        bit seen;
        clear_track();
        push_stage(0);
        bus.i_ready = 1'b0;
        start_stage(0);
        seen = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            if (o_done) begin seen = 1'b1; break; end
            @(posedge clk); #1;
            bus.i_ready = 1'($urandom_range(0, 1));
        end
        checks++;
        if (!seen || words_seen != 39 || exp_q.size() != 0 || addr_q.size() != 0) begin
            errors++;
            $display("FAIL backpressure: done=%b words=%0d left=%0d reads_left=%0d, required 1 39 0 0",
                     seen, words_seen, exp_q.size(), addr_q.size());
        end
        bus.i_ready = 1'b1;
    endtask

    task automatic test_bad_stage();
        bit bad;
        clear_track();
        @(posedge clk); #1;
        i_stage = 5'd25; i_start = 1'b1;
        @(negedge clk);
        checks++;
        if (o_err !== 1'b1 || bus.o_mem_rd !== 1'b0) begin
            errors++;
            $display("FAIL bad_stage_err: err=%b rd=%b, required 1 0", o_err, bus.o_mem_rd);
        end
        @(posedge clk); #1;
        i_start = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (o_busy || o_err || bus.o_mem_rd) bad = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL bad_stage_idle: activity=1, required 0");
        end
        // Stage 2 has N == 0: error in CNT_WAIT (cycle 3), then idle.
        clear_track();
        push_stage(2);
        start_stage(2);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if (o_err !== 1'(c == 3) || o_busy !== 1'(c < 4)) begin
                errors++;
                $display("FAIL n_zero_cycle_%0d: err=%b busy=%b, required %b %b",
                         c, o_err, o_busy, 1'(c == 3), 1'(c < 4));
            end
            @(posedge clk); #1;
        end
        bad = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.o_valid || o_done) bad = 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if (bad || addr_q.size() != 0) begin
            errors++;
            $display("FAIL n_zero_quiet: activity=%b reads_left=%0d, required 0 0", bad, addr_q.size());
        end
    endtask

    task automatic test_abort();
        bit seen, bad;
        clear_track();
        push_stage(0);
        bus.i_ready = 1'b1;
        start_stage(0);
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (words_seen == 9) break;
        end
        i_abort = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.o_valid !== 1'b1 || words_seen != 9) begin
            errors++;
            $display("FAIL abort_setup: valid=%b words=%0d, required 1 9", bus.o_valid, words_seen);
        end
        @(posedge clk); #1;
        i_abort = 1'b0;
        exp_q.delete(); addr_q.delete(); out_cnt = 0;
        @(negedge clk);
        checks++;
        if (bus.o_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || words_seen != 9) begin
            errors++;
            $display("FAIL abort_effect: valid=%b busy=%b done=%b words=%0d, required 0 0 0 9",
                     bus.o_valid, o_busy, o_done, words_seen);
        end
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (bus.o_valid || o_done || o_err) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL abort_quiet: activity=1, required 0");
        end
        clear_track();
        push_stage(1);
        start_stage(1);
        wait_done(100, seen);
        checks++;
        if (!seen || words_seen != 21 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL restart_after_abort: done=%b words=%0d left=%0d, required 1 21 0",
                     seen, words_seen, exp_q.size());
        end
    endtask

    task automatic test_reset_midstream();
        logic [63:0] outs;
        bit bad;
        clear_track();
        push_stage(0);
        bus.i_ready = 1'b0;
        start_stage(0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
        end
        reset = 1'b1; i_start = 1'b1; i_abort = 1'b1;
        @(negedge clk);
        outs = 64'({bus.o_valid, bus.o_mem_rd, bus.o_mem_addr, bus.o_data, bus.o_index_classifier,
                    bus.o_index_param, bus.o_is_threshold, bus.o_end_classifier, bus.o_end_stage,
                    o_busy, o_done, o_err});
        checks++;
        if (outs !== 64'd0) begin
            errors++;
            $display("FAIL midstream_reset_outputs: got %h, required 0", outs);
        end
        @(posedge clk); #1;
        reset = 1'b0; i_start = 1'b0; i_abort = 1'b0;
        clear_track();
        bus.i_ready = 1'b1;
        @(negedge clk);
        outs = 64'({bus.o_valid, bus.o_mem_rd, bus.o_data, o_busy, o_done, o_err});
        checks++;
        if (outs !== 64'd0) begin
            errors++;
            $display("FAIL midstream_reset_after: got %h, required 0", outs);
        end
        bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (bus.o_valid || o_busy || bus.o_mem_rd) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL late_data_ignored: activity=1, required 0");
        end
    endtask

    task automatic test_wrap();
        bit seen;
        clear_track();
        push_stage(3);
        bus.i_ready = 1'b1;
        start_stage(3);
        wait_done(100, seen);
        checks++;
        if (!seen || words_seen != 21 || exp_q.size() != 0 || addr_q.size() != 0) begin
            errors++;
            $display("FAIL addr_wrap: done=%b words=%0d left=%0d reads_left=%0d, required 1 21 0 0",
                     seen, words_seen, exp_q.size(), addr_q.size());
        end
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = 12'((a * 37 + 11) ^ (a >> 3));
        mem[0] = 12'h100; mem[1] = 12'd2;
        mem[2] = 12'h200; mem[3] = 12'd1;
        mem[4] = 12'h300; mem[5] = 12'd0;
        mem[6] = 12'hFF0; mem[7] = 12'd1;
        bus.i_ready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_bad_stage();
        test_abort();
        test_reset_midstream();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
